// File: rtl/sony_block_stream_gen.sv
// Transmit-side Sony block-camera stream: embedded-sync 16-bit words with blanking fill and active pixels.
// Outputs are registered one cycle after the h/v counter state that produces them; pix_ready is decoded from that state.
module sony_block_stream_gen #(
  parameter int          H_ACTIVE   = 1920,
  parameter int          H_TOTAL    = 2200,
  parameter int          V_ACTIVE   = 1080,
  parameter int          V_TOTAL    = 1125,
  parameter logic [15:0] SAV_FIRST  = 16'h8080,
  parameter logic [15:0] SAV_ACT    = 16'hABAB,
  parameter logic [15:0] EAV_ACT    = 16'h9D9D,
  parameter logic [15:0] CODE_BLANK = 16'hB6B6,
  parameter logic [15:0] BLANK_FILL = 16'h8010
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] data_out,
  output logic        FV,
  output logic        LV,
  output logic        frame_start,
  output logic        underflow
);

  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SAV_POS = H_TOTAL - H_ACTIVE - 4;
  localparam int ACT_POS = H_TOTAL - H_ACTIVE;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] EAV_END  = HW'(4);
  localparam logic [HW-1:0] SAV_L    = HW'(SAV_POS);
  localparam logic [HW-1:0] ACT_L    = HW'(ACT_POS);
  localparam logic [HW-1:0] FS_L     = HW'(SAV_POS + 3);
  localparam logic [1:0]    SAV_IDX0 = 2'(SAV_POS);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic          run;
  logic          active_line;
  logic          prev_active;
  logic [15:0]   eav_code;
  logic [15:0]   sav_code;
  logic [1:0]    sav_idx;
  logic [15:0]   word;

  function automatic logic [15:0] sync_word(input logic [1:0] idx, input logic [15:0] code);
    case (idx)
      2'd0:    return 16'hFFFF;
      2'd3:    return code;
      default: return 16'h0000;
    endcase
  endfunction

  // 00 and FF bytes are reserved for the sync preamble.
  function automatic logic [7:0] clamp8(input logic [7:0] b);
    if (b == 8'h00)      return 8'h01;
    else if (b == 8'hFF) return 8'hFE;
    else                 return b;
  endfunction

  always_comb begin
    run         = (state == RUN);
    active_line = (v_cnt < V_ACT_L);
    prev_active = (v_cnt != '0) && (v_cnt <= V_ACT_L);
    eav_code    = prev_active ? EAV_ACT : CODE_BLANK;
    sav_code    = (v_cnt == '0) ? SAV_FIRST : (active_line ? SAV_ACT : CODE_BLANK);
    sav_idx     = h_cnt[1:0] - SAV_IDX0;
    pix_ready   = run && active_line && (h_cnt >= ACT_L);
    word        = BLANK_FILL;
    if (run) begin
      if (h_cnt < EAV_END)
        word = sync_word(h_cnt[1:0], eav_code);
      else if (h_cnt >= SAV_L && h_cnt < ACT_L)
        word = sync_word(sav_idx, sav_code);
      else if (pix_ready && pix_valid)
        word = {clamp8(pix_data[15:8]), clamp8(pix_data[7:0])};
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      data_out    <= BLANK_FILL;
      FV          <= 1'b0;
      LV          <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      data_out    <= word;
      FV          <= run && active_line;
      LV          <= pix_ready;
      frame_start <= run && (v_cnt == '0) && (h_cnt == FS_L);
      if (pix_ready && !pix_valid)
        underflow <= 1'b1;

      case (state)
        IDLE: begin
          h_cnt <= '0;
          v_cnt <= '0;
          if (enable)
            state <= RUN;
        end
        RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
              // enable only takes effect at the frame boundary
              v_cnt <= '0;
              if (!enable)
                state <= IDLE;
            end else begin
              v_cnt <= v_cnt + 1'b1;
            end
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
